// File: rtl/memory_bank_be.sv
`default_nettype none
// ============================================================================
// Module   : memory_bank_be
// Brief    : Simple-dual-port RAM with per-byte write enables, 1- or 2-cycle
//            read latency, read valid strobe and an optional post-reset
//            zero sweep.
// Revision : 1.0 - initial release
// ============================================================================
module memory_bank_be #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cs,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    busy
);

    localparam int DEPTH     = 2**ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH/8;

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;

    logic                  w_ready;
    logic                  w_clr_en;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_ready  = (r_state == c_ST_READY);
    assign w_clr_en = !reset && (r_state == c_ST_CLEAR);
    assign w_wr_en  = !reset && w_ready && cs && we;
    assign w_rd_en  = !reset && w_ready && cs && re;
    assign busy     = (r_state == c_ST_CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_cnt <= '0;
            r_state   <= (CLEAR_ON_RESET != 0) ? c_ST_CLEAR : c_ST_READY;
        end else if (r_state == c_ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == c_LAST_ADDR) begin
                r_state <= c_ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr_en) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_en) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_be[b]) begin
                    r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Write-first bypass: a same-address write in the capture cycle is merged lane by lane.
    always_comb begin
        w_rd_word = r_mem[rd_addr];
        if (w_wr_en && (wr_addr == rd_addr)) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_be[b]) begin
                    w_rd_word[8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= w_rd_en;
                    if (w_rd_en) begin
                        rd_data <= w_rd_word;
                    end
                end
            end
        end else begin : g_lat2
            logic                  r_pipe_valid;
            logic [DATA_WIDTH-1:0] r_pipe_data;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pipe_valid <= 1'b0;
                    r_pipe_data  <= '0;
                    rd_data      <= '0;
                    rd_valid     <= 1'b0;
                end else begin
                    r_pipe_valid <= w_rd_en;
                    if (w_rd_en) begin
                        r_pipe_data <= w_rd_word;
                    end
                    rd_valid <= r_pipe_valid;
                    if (r_pipe_valid) begin
                        rd_data <= r_pipe_data;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_memory_bank_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_bank_be
// Brief    : Self-checking bench for memory_bank_be; latency-1, latency-2 and
//            no-clear instances share stimulus and a behavioural memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_bank_be;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        we;
    logic        re;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [7:0]  rd_addr;

    logic [31:0] rd_data1, rd_data2, rd_data3;
    logic        rd_valid1, rd_valid2, rd_valid3;
    logic        busy1, busy2, busy3;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: array of words, remaining busy edges, expected outputs
    logic [31:0] m_mem [256];
    int          m_busy;
    bit          e1v, e2v, p_v;
    logic [31:0] e1d, e2d, p_d;

    memory_bank_be #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .re(re), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .busy(busy1));

    memory_bank_be #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut2 (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .re(re), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .busy(busy2));

    memory_bank_be #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut3 (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .re(re), .rd_addr(rd_addr), .rd_data(rd_data3), .rd_valid(rd_valid3),
        .busy(busy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Drive one cycle of inputs, advance one edge, update the model, settle 1 time unit.
    task automatic step(input bit a_rst, input bit a_cs, input bit a_we, input logic [7:0] a_wa,
                        input logic [31:0] a_wd, input logic [3:0] a_be, input bit a_re,
                        input logic [7:0] a_ra);
        logic [31:0] word;
        bit          acc;
        reset = a_rst; cs = a_cs; we = a_we; wr_addr = a_wa; wr_data = a_wd;
        wr_be = a_be; re = a_re; rd_addr = a_ra;
        @(posedge clk);
        if (a_rst) begin
            m_busy = 256;
            for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
            e1v = 0; e1d = 32'h0; e2v = 0; e2d = 32'h0; p_v = 0; p_d = 32'h0;
        end else if (m_busy > 0) begin
            m_busy--;
            e1v = 0;
            e2v = p_v;
            if (p_v) e2d = p_d;
            p_v = 0;
        end else begin
            acc = a_cs && a_re;
            if (a_cs && a_we)
                for (int b = 0; b < 4; b++)
                    if (a_be[b]) m_mem[a_wa][8*b +: 8] = a_wd[8*b +: 8];
            word = m_mem[a_ra];
            e2v = p_v;
            if (p_v) e2d = p_d;
            p_v = acc;
            if (acc) p_d = word;
            e1v = acc;
            if (acc) e1d = word;
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 8'h0, 32'h0, 4'h0, 0, 8'h0);
    endtask

    task automatic test_reset();
        int n;
        step(1, 0, 0, 8'h0, 32'h0, 4'h0, 0, 8'h0);
        step(1, 1, 1, 8'h3, 32'h1234, 4'hF, 1, 8'h3);
        n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy1); end
        n_tests++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL reset_busy_noclear: got %b expected 0", busy3); end
        n_tests++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0 || rd_valid3 !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b%b%b expected 000", rd_valid1, rd_valid2, rd_valid3); end
        n_tests++; if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h expected 0", rd_data1, rd_data2); end
        n = 0;
        do begin idle(); n++; end while (busy1 === 1'b1 && n < 400);
        n_tests++; if (n != 256) begin n_fail++; $display("FAIL sweep_len: got %0d expected 256", n); end
        n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL sweep_end_lat2: got %b expected 0", busy2); end
    endtask

    task automatic test_clear_reads();
        logic [7:0] addrs [3];
        addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 8'h0, 32'h0, 4'h0, 1, addrs[k]);
            n_tests++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin
                n_fail++; $display("FAIL clear_read1 @%h: got v=%b d=%h expected v=1 d=0", addrs[k], rd_valid1, rd_data1); end
            idle();
            n_tests++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h0 || rd_valid1 !== 1'b0) begin
                n_fail++; $display("FAIL clear_read2 @%h: got v2=%b d2=%h v1=%b expected 1/0/0", addrs[k], rd_valid2, rd_data2, rd_valid1); end
        end
    endtask

    task automatic test_full_write();
        step(0, 1, 1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 8'h0);
        n_tests++; if (rd_valid1 !== 1'b0) begin n_fail++; $display("FAIL write_no_valid: got %b expected 0", rd_valid1); end
        step(0, 1, 0, 8'h0, 32'h0, 4'h0, 1, 8'h10);
        n_tests++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL full_write_lat1: got v=%b d=%h expected v=1 d=deadbeef", rd_valid1, rd_data1); end
        n_tests++; if (rd_valid2 !== 1'b0) begin n_fail++; $display("FAIL full_write_lat2_early: got %b expected 0", rd_valid2); end
        n_tests++; if (rd_valid3 !== 1'b1 || rd_data3 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL full_write_noclear: got v=%b d=%h expected v=1 d=deadbeef", rd_valid3, rd_data3); end
        idle();
        n_tests++; if (rd_valid1 !== 1'b0 || rd_data1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL hold_lat1: got v=%b d=%h expected v=0 d=deadbeef", rd_valid1, rd_data1); end
        n_tests++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL full_write_lat2: got v=%b d=%h expected v=1 d=deadbeef", rd_valid2, rd_data2); end
    endtask

    task automatic test_byte_enable();
        step(0, 1, 1, 8'h10, 32'h11223344, 4'b0101, 0, 8'h0);
        step(0, 1, 0, 8'h0, 32'h0, 4'h0, 1, 8'h10);
        n_tests++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hDE22BE44) begin
            n_fail++; $display("FAIL byte_enable: got v=%b d=%h expected v=1 d=de22be44", rd_valid1, rd_data1); end
        step(0, 1, 1, 8'h10, 32'hFFFFFFFF, 4'h0, 0, 8'h0);
        step(0, 1, 0, 8'h0, 32'h0, 4'h0, 1, 8'h10);
        n_tests++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hDE22BE44) begin
            n_fail++; $display("FAIL be_zero_noop: got v=%b d=%h expected v=1 d=de22be44", rd_valid1, rd_data1); end
        idle();
    endtask

    task automatic test_same_cycle();
        step(0, 1, 1, 8'h20, 32'hCAFEF00D, 4'b1100, 1, 8'h20);
        n_tests++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hCAFE0000) begin
            n_fail++; $display("FAIL write_first_lat1: got v=%b d=%h expected v=1 d=cafe0000", rd_valid1, rd_data1); end
        // Overwrite the same word while the latency-2 result is in flight.
        step(0, 1, 1, 8'h20, 32'h12345678, 4'hF, 0, 8'h0);
        n_tests++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'hCAFE0000) begin
            n_fail++; $display("FAIL write_first_lat2: got v=%b d=%h expected v=1 d=cafe0000", rd_valid2, rd_data2); end
        step(0, 1, 1, 8'h21, 32'hA5A5A5A5, 4'hF, 1, 8'h20);
        n_tests++; if (rd_data1 !== 32'h12345678) begin
            n_fail++; $display("FAIL diff_addr_read: got %h expected 12345678", rd_data1); end
        idle();
    endtask

    task automatic test_busy_ignore();
        int n;
        bit seen;
        seen = 0;
        step(1, 0, 0, 8'h0, 32'h0, 4'h0, 0, 8'h0);
        for (int k = 0; k < 100; k++) begin
            step(0, 1, 1, 8'h05, 32'h55, 4'hF, 1, 8'h05);
            if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) seen = 1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL busy_valid: got 1 expected 0"); end
        step(1, 1, 1, 8'h05, 32'h55, 4'hF, 1, 8'h05);
        n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL midclear_reset_busy: got %b expected 1", busy1); end
        n = 0;
        do begin step(0, 1, 1, 8'h05, 32'h55, 4'hF, 0, 8'h0); n++; end while (busy1 === 1'b1 && n < 400);
        n_tests++; if (n != 256) begin n_fail++; $display("FAIL midclear_sweep_len: got %0d expected 256", n); end
        step(0, 1, 0, 8'h0, 32'h0, 4'h0, 1, 8'h05);
        n_tests++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin
            n_fail++; $display("FAIL busy_write_ignored: got v=%b d=%h expected v=1 d=0", rd_valid1, rd_data1); end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) step(0, 1, 1, 8'(i), 32'(i*3), 4'hF, 0, 8'h0);
        for (int k = 0; k < 18; k++) begin
            if (k < 16) step(0, 1, 0, 8'h0, 32'h0, 4'h0, 1, 8'(k));
            else idle();
            n_tests++;
            if (rd_valid2 !== ((k >= 1 && k <= 16) ? 1'b1 : 1'b0) ||
                (k >= 1 && k <= 16 && rd_data2 !== 32'((k-1)*3))) begin
                n_fail++; $display("FAIL b2b_lat2 step %0d: got v=%b d=%h expected v=%b d=%0d", k, rd_valid2, rd_data2,
                                   (k >= 1 && k <= 16), (k-1)*3); end
            n_tests++;
            if (rd_valid1 !== ((k < 16) ? 1'b1 : 1'b0) || (k < 16 && rd_data1 !== 32'(k*3))) begin
                n_fail++; $display("FAIL b2b_lat1 step %0d: got v=%b d=%h expected v=%b d=%0d", k, rd_valid1, rd_data1,
                                   (k < 16), k*3); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            step(0, ($urandom_range(0, 9) != 0), $urandom_range(0, 1), 8'($urandom_range(0, 15)),
                 $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 1), 8'($urandom_range(0, 15)));
            n_tests++; if (rd_valid1 !== e1v || rd_data1 !== e1d) begin
                n_fail++; $display("FAIL rand_lat1 cyc %0d: got v=%b d=%h expected v=%b d=%h", k, rd_valid1, rd_data1, e1v, e1d); end
            n_tests++; if (rd_valid2 !== e2v || rd_data2 !== e2d) begin
                n_fail++; $display("FAIL rand_lat2 cyc %0d: got v=%b d=%h expected v=%b d=%h", k, rd_valid2, rd_data2, e2v, e2d); end
            n_tests++; if (busy1 !== (m_busy > 0)) begin
                n_fail++; $display("FAIL rand_busy cyc %0d: got %b expected %b", k, busy1, (m_busy > 0)); end
        end
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; we = 1'b0; re = 1'b0;
        wr_addr = 8'h0; wr_data = 32'h0; wr_be = 4'h0; rd_addr = 8'h0;
        test_reset();
        test_clear_reads();
        test_full_write();
        test_byte_enable();
        test_same_cycle();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_bank_be.md
Name: memory_bank_be

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port with per-byte enables, one read port with configurable read latency.
- Read port also has a valid strobe. An optional hardware clear sweep runs after reset.
- Next-generation replacement for the single-port `memory` block. Used as a general scratch/buffer store behind the same `cs`/`we`/`re` command style.

Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words (no out-of-range addresses exist).
- DATA_WIDTH, 32, word width; must be a multiple of 8; NUM_BYTES = DATA_WIDTH/8.
- READ_LATENCY, 1, cycles from read capture edge to rd_data/rd_valid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents untouched by reset.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  chip select; gates both we and re.
- we  input  1  write request (qualified by cs).
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- wr_be  input  NUM_BYTES  byte enables; bit i covers wr_data[8i+7:8i].
- re  input  1  read request (qualified by cs).
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  read data; holds its last value between reads.
- rd_valid  output  1  one-cycle strobe per accepted read.
- busy  output  1  high while the clear sweep runs; all requests are ignored while high.

Behaviour:
- Reset (sampled at posedge while reset=1):
  - rd_data <= 0; rd_valid <= 0; read pipeline flushed.
  - clr_cnt <= 0.
  - state <= CLEAR and busy <= 1 if CLEAR_ON_RESET=1, else state <= READY and busy <= 0.
  - Memory array is not touched in the reset cycle itself.
- FSM states: CLEAR, READY.
  - CLEAR: each posedge with reset=0 writes 0 to mem[clr_cnt], then clr_cnt++.
  - When clr_cnt == DEPTH-1, that word is written and state <= READY, busy <= 0.
  - busy is therefore high for exactly DEPTH posedges after reset deasserts.
  - cs/we/re are ignored in CLEAR: no write, no rd_valid, nothing queued.
- Reset mid-CLEAR restarts the sweep from address 0 with the full DEPTH-cycle duration.
- READY write: at a posedge with cs=1 and we=1, lane i of mem[wr_addr] <= wr_data lane i for every wr_be[i]=1. Other lanes are unchanged; wr_be=0 is a no-op.
- READY read: at a posedge with cs=1 and re=1, rd_addr is captured.
  - READ_LATENCY=1: rd_data is updated and rd_valid=1 after that same edge (visible the next cycle), for one cycle.
  - READ_LATENCY=2: update and strobe occur one edge later.
  - Throughput is one read per cycle; back-to-back reads give continuous rd_valid with data in request order.
- rd_valid is low in every cycle with no read result; rd_data holds its previous value.
- Read and write in the same cycle:
  - Different addresses: both are performed independently.
  - Same address: write-first. Returned word = new bytes where wr_be=1, old bytes elsewhere.
- The read value is fixed at the capture edge. A write in the cycle between capture and output (latency 2) does not alter the in-flight result.
- cs=0: no operation regardless of we/re.
- Reset takes priority over all requests in the same cycle; an in-flight latency-2 read is dropped and produces no rd_valid.

Test Plan:
1. DEPTH=256, CLEAR_ON_RESET=1: reset for 2 cycles, release -> busy=1 for exactly 256 posedges then 0; reads of addr 0x00, 0x7F, 0xFF return 0x00000000 with rd_valid.
2. Write 0xDEADBEEF to 0x10 with wr_be=4'hF, read 0x10 next cycle -> rd_data=0xDEADBEEF, rd_valid high one cycle after the capture edge (READ_LATENCY=1).
3. Write 0x11223344 with wr_be=4'b0101 over 0xDEADBEEF at 0x10, then read -> 0xDE22BE44. A write with wr_be=0 followed by a read still returns 0xDE22BE44.
4. Addr 0x20 holds 0; in the same cycle write 0xCAFEF00D (wr_be=4'b1100) and read 0x20 -> rd_data=0xCAFE0000.
5. Write 0x55 to addr 5 while busy=1 -> ignored, later read returns 0. Assert reset when clr_cnt=100 -> busy stays high for a full 256 posedges after release.
6. READ_LATENCY=2: write addr 0..15 with value addr*3, then issue reads 0..15 on consecutive cycles -> rd_valid high 16 consecutive cycles starting 2 edges after the first read; rd_data = 0,3,6,...,45 in order.
